// File: rtl/traffic_pkg.sv
// Constants shared by the traffic light controller and its sensor front end.
// Holds the light state encoding and the default timing parameters.
package traffic_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int MAX_GREEN_DEF  = 64;

  typedef enum logic [3:0] {
    s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12
  } light_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer and debounce filter for one loop detector.
// A new level is accepted only after DEB_CYCLES consecutive stable samples.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic det
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          sync_x;
  logic          det_reg, det_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  assign sync_x = sync_reg[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      det_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      det_reg  <= det_next;
      cnt_reg  <= cnt_next;
    end
  end

  // The counter runs only while the synchronized level disagrees with det.
  always_comb begin
    det_next = det_reg;
    cnt_next = '0;
    if (sync_x != det_reg) begin
      if (cnt_reg == CNT_LAST) begin
        det_next = sync_x;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  assign det = det_reg;

endmodule

// File: rtl/sensor_conditioner.sv
// Turns raw loop-detector inputs into latched service requests Sa/Sb,
// cleared on own-road green and forced after prolonged opposite green.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int MAX_GREEN  = MAX_GREEN_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_b,
  input  logic Ga,
  input  logic Gb,
  output logic Sa,
  output logic Sb
);

  localparam int WW = cnt_width(MAX_GREEN);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_GREEN);

  logic [1:0] raw;
  logic [1:0] det;
  logic [1:0] req;
  logic       both_green;

  assign raw        = {raw_b, raw_a};
  assign both_green = Ga & Gb;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          own_green, other_green, force_req;
      logic [WW-1:0] wait_reg, wait_next;
      logic          req_reg, req_next;

      assign own_green   = (gi == 0) ? Ga : Gb;
      assign other_green = (gi == 0) ? Gb : Ga;

      sensor_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (raw[gi]),
        .det    (det[gi])
      );

      assign force_req = (wait_reg == WAIT_MAX);

      // An illegal both-green also clears the timer; own green clears the request.
      always_comb begin
        wait_next = '0;
        if (other_green && !both_green) begin
          wait_next = force_req ? wait_reg : wait_reg + WW'(1);
        end
        req_next = req_reg;
        if (own_green) begin
          req_next = 1'b0;
        end else if (det[gi] || force_req) begin
          req_next = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wait_reg <= '0;
          req_reg  <= 1'b0;
        end else begin
          wait_reg <= wait_next;
          req_reg  <= req_next;
        end
      end

      assign req[gi] = req_reg;
    end
  endgenerate

  assign Sa = req[0];
  assign Sb = req[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_sensor_conditioner;

  localparam int DEB = 4;
  localparam int MAXG = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic raw_a = 1'b0, raw_b = 1'b0, Ga = 1'b0, Gb = 1'b0;
  logic Sa, Sb;

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0] expq[$];

  // Behavioural model state: sampled histories and per-road status.
  bit rh[2][64];
  bit sh[2][64];
  bit mdet[2];
  bit mreq[2];
  int run[2];
  int n;

  sensor_conditioner #(
    .DEB_CYCLES(DEB),
    .MAX_GREEN (MAXG)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .Ga     (Ga),
    .Gb     (Gb),
    .Sa     (Sa),
    .Sb     (Sb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 64; k++) begin
        rh[c][k] = 1'b0;
        sh[c][k] = 1'b0;
      end
      mdet[c] = 1'b0;
      mreq[c] = 1'b0;
      run[c]  = 0;
    end
    n = 0;
  endtask

  // One rising edge with the given sampled inputs; returns requests after it.
  task automatic model_step(input bit ra, input bit rb, input bit ga, input bit gb,
                            output bit ea, output bit eb);
    n++;
    for (int c = 0; c < 2; c++) begin
      bit own, oth, r, frc, sync_pre, all_diff;
      own = (c == 0) ? ga : gb;
      oth = (c == 0) ? gb : ga;
      r   = (c == 0) ? ra : rb;
      frc = (run[c] >= MAXG);
      if (own) mreq[c] = 1'b0;
      else if (mdet[c] || frc) mreq[c] = 1'b1;
      // Detector level seen by the filter lags the sampled raw input by two edges.
      rh[c][n % 64] = r;
      sync_pre = rh[c][(n + 62) % 64];
      sh[c][n % 64] = sync_pre;
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (sh[c][(n + 64 - k) % 64] == mdet[c]) all_diff = 1'b0;
      if (all_diff) mdet[c] = ~mdet[c];
      run[c] = (oth && !own) ? run[c] + 1 : 0;
    end
    ea = mreq[0];
    eb = mreq[1];
  endtask

  task automatic step(input bit ra, input bit rb, input bit ga, input bit gb);
    bit ea, eb;
    raw_a = ra; raw_b = rb; Ga = ga; Gb = gb;
    model_step(ra, rb, ga, gb, ea, eb);
    expq.push_back({ea, eb});
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected {Sa,Sb} per clock edge issued by the stimulus.
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("scoreboard_sa_sb", {Sa, Sb}, e);
    end
  end

  initial begin
    model_reset();
    raw_a = 1'b1; raw_b = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_sa", Sa, 0);
    check("reset_sb", Sb, 0);
    Ga = 1'b1;
    reset_n = 1'b1;

    // Release with road A green: Sb rises after edge 7, Sa stays low.
    for (int e = 1; e <= 7; e++) begin
      step(1, 1, 1, 0);
      if (e == 6) check("release_sb_edge6", Sb, 0);
      if (e == 7) check("release_sb_edge7", Sb, 1);
      check("release_sa_low", Sa, 0);
    end

    // Settle: drop detectors and serve both roads.
    repeat (8) step(0, 0, 0, 1);
    repeat (8) step(0, 0, 1, 0);

    // Glitch on raw_b shorter than the debounce window.
    check("glitch_sb_before", Sb, 0);
    repeat (3) begin
      step(0, 1, 1, 0);
      check("glitch_det_b", dut.det[1], 0);
    end
    repeat (8) begin
      step(0, 0, 1, 0);
      check("glitch_det_b", dut.det[1], 0);
      check("glitch_sb", Sb, 0);
    end

    // Latch then clear on road A.
    for (int e = 1; e <= 10; e++) begin
      step(1, 0, 0, 1);
      if (e == 6) check("latch_sa_edge6", Sa, 0);
      if (e == 7) check("latch_sa_edge7", Sa, 1);
    end
    repeat (6) begin
      step(0, 0, 0, 1);
      check("latch_sa_hold", Sa, 1);
    end
    step(0, 0, 1, 0);
    check("clear_sa", Sa, 0);

    // Own-green suppression.
    repeat (12) begin
      step(1, 0, 1, 0);
      check("own_green_sa", Sa, 0);
    end
    repeat (8) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Starvation: Ga held, Sb forced after edge MAXG+1.
    for (int e = 1; e <= MAXG + 1; e++) begin
      step(0, 0, 1, 0);
      if (e == MAXG) check("starve_sb_edge64", Sb, 0);
      if (e == MAXG + 1) check("starve_sb_edge65", Sb, 1);
    end
    step(0, 0, 0, 1);
    check("starve_sb_served", Sb, 0);
    check("starve_wait_b", int'(dut.g_chan[1].wait_reg), 0);

    // Reset mid-operation.
    repeat (8) step(1, 1, 0, 0);
    check("pre_reset_sa", Sa, 1);
    check("pre_reset_sb", Sb, 1);
    raw_a = 1'b0; raw_b = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_sa", Sa, 0);
    check("async_reset_sb", Sb, 0);
    reset_n = 1'b1;
    model_reset();
    repeat (10) begin
      step(0, 0, 0, 0);
      check("post_reset_sa", Sa, 0);
      check("post_reset_sb", Sb, 0);
    end

    // Randomized phases of green with bouncy detectors.
    begin
      bit ra, rb, ga, gb;
      int phase_left;
      ra = 0; rb = 0; ga = 0; gb = 0; phase_left = 0;
      for (int i = 0; i < 3000; i++) begin
        if (phase_left == 0) begin
          int sel;
          sel = $urandom_range(0, 19);
          ga = (sel < 8) || (sel == 19);
          gb = (sel >= 8 && sel < 16) || (sel == 19);
          phase_left = (sel == 19) ? $urandom_range(1, 3) : $urandom_range(1, 90);
        end
        phase_left--;
        if ($urandom_range(0, 5) == 0) ra = ~ra;
        if ($urandom_range(0, 5) == 0) rb = ~rb;
        step(ra, rb, ga, gb);
      end
    end

    @(posedge clk);
    #3;
    check("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Upstream stage of the traffic light `controller`. It takes the raw, asynchronous, bouncy loop-detector signals for road A and road B and produces the clean, latched request inputs `Sa` and `Sb`. Each request holds until the requesting road is actually served green, as reported back by the controller's `Ga`/`Gb` outputs. A starvation fallback forces a request if the opposite road has held green for too long.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable cycles needed to accept a new detector level. Legal range is 1 or more.
- `MAX_GREEN`, default 64: cycles of continuous opposite-road green after which a request is forced. Legal range is 1 or more.

Ports:
- `clk`  in  1: system clock, the same clock that drives `controller`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `raw_a`  in  1: road A vehicle detector. Asynchronous, may bounce.
- `raw_b`  in  1: road B vehicle detector. Asynchronous, may bounce.
- `Ga`  in  1: road A green, fed back from `controller`.
- `Gb`  in  1: road B green, fed back from `controller`.
- `Sa`  out  1: registered request for road A service.
- `Sb`  out  1: registered request for road B service.

## Operation
The block has two identical channels, x in {a,b}. The "own" green of channel x is `Gx`; the "other" green is the opposite road's green.
- **Synchronizer:** `raw_x` passes through 2 flops to give `sync_x`.
- **Debounce:**
  - Holds a level `det_x` and a counter `cnt_x` of width clog2(DEB_CYCLES+1).
  - If `sync_x == det_x`: `cnt_x` <= 0.
  - Otherwise, if `cnt_x == DEB_CYCLES-1`: `det_x` <= `sync_x` and `cnt_x` <= 0.
  - Otherwise: `cnt_x` increments.
  - Any glitch shorter than DEB_CYCLES cycles is discarded.
- **Starvation timer `wait_x`:**
  - Counts cycles while the other green is 1.
  - Saturates at MAX_GREEN.
  - Clears to 0 in any cycle the other green is 0.
  - `force_x` is true when `wait_x == MAX_GREEN`.
- **Request latch `Sx`, priority order:**
  1. Own green is 1: `Sx` <= 0 (the road is being served; a detection during its own green needs no request).
  2. Else `det_x` is 1 or `force_x` is 1: `Sx` <= 1.
  3. Else `Sx` holds.
- `Sx` stays set after the vehicle leaves the loop (`det_x` falls). It clears only on service.
- If `Ga` and `Gb` are both 1 (illegal from the controller), both requests clear and both timers clear. There is no error output.
- The channels are fully independent. Simultaneous events on A and B need no arbitration.

## Timing
- Reset value is 0 for all state: sync flops, `det_x`, `cnt_x`, `wait_x`, `Sa`, `Sb`.
- Reset asserted mid-operation drops `Sa`/`Sb` to 0 immediately (asynchronous). Pending requests are lost.
- Latency from `raw_x` rising (settled before edge 0, then held) to `Sx` = 1 is DEB_CYCLES+3 rising edges:
  - `sync_x` goes high after edge 2.
  - `det_x` goes high after edge DEB_CYCLES+2.
  - `Sx` goes high after edge DEB_CYCLES+3.
- With the defaults, `Sa` rises after edge 7.
- Clear latency: `Sx` is 0 after the first edge at which own green is sampled 1.
- Force: with the other green held from edge 0, `wait_x` reaches MAX_GREEN after edge MAX_GREEN, and `Sx` sets after edge MAX_GREEN+1.
- When the other green drops, `wait_x` is 0 after the next edge.

## Structure
- Shared package `traffic_pkg` holds:
  - `DEB_CYCLES_DEF` = 4
  - `MAX_GREEN_DEF` = 64
  - the light state encoding constants `s0`..`s12`, shared with `controller`.
- Sub-module `sensor_debounce` contains the synchronizer plus the debounce logic for one detector (ports `clk`, `reset_n`, `raw`, `det`). It is instantiated twice.
- The request latch and starvation timer live in `sensor_conditioner`.

## Test plan
- **Reset:** hold `reset_n` = 0 with `raw_a`=`raw_b`=1 → `Sa`=`Sb`=0. Release it with `Ga`=1, `Gb`=0 → `Sb`=1 after edge 7; `Sa` stays 0.
- **Glitch reject:** pulse `raw_b` high for 3 cycles (DEB_CYCLES=4) with `Ga`=1 → `Sb` never asserts and the debounced level `det_b` stays 0.
- **Latch then clear:**
  - Press `raw_a` for 10 cycles with `Gb`=1 → `Sa`=1 after edge 7 and stays 1 after `raw_a` falls.
  - Switch to `Ga`=1 → `Sa`=0 one edge later.
- **Own-green suppression:** `raw_a` high while `Ga`=1 → `Sa` stays 0 throughout.
- **Starvation:** all raw inputs 0, `Ga`=1 held, MAX_GREEN=64 → `Sb`=1 after edge 65. Then `Gb`=1 → `Sb`=0, and `wait_b` is 0.
- **Reset mid-operation:** with `Sa`=`Sb`=1, pulse `reset_n` low between edges → both outputs go to 0 asynchronously. After release, with raw inputs 0, both remain 0.
